primitive_ap02_llii: RTL and testbench

PRIMITIVE_AP02_LLII -- requirements
Module: primitive_ap02_llii

---
 rtl/primitives_pkg.sv | 26 ++
 rtl/primitive_ap01_lli.sv | 46 ++++
 rtl/primitive_ap02_llii.sv | 96 +++++++++
 tb/tb_primitive_ap02_llii.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/primitives_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | primitives_pkg                                                     |
// | Shared stream-word layout, pop-counter states and read() builder.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package primitives_pkg;

    localparam int c_N      = 8;
    localparam int c_W      = c_N + 1;
    localparam int c_R_BIT  = c_N;
    localparam int c_D_MSB  = c_N - 1;
    localparam int c_D_LSB  = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        BOTH  = 2'd2
    } popCnt_e;

    function automatic logic [c_W-1:0] read(input logic [c_N-1:0] value);
        return {1'b1, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/primitive_ap01_lli.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | primitive_ap01_lli                                                 |
// | Pops the first valid element into d_out (held); later valid        |
// | elements pass to s_out one cycle later, bubbles become zero.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module primitive_ap01_lli
    import primitives_pkg::*;
#(
    parameter int N = c_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [N:0] s_in,
    output logic [N:0] s_out,
    output logic [N:0] d_out
);

    logic       r_have;
    logic [N:0] r_sOut;
    logic [N:0] r_dOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_have <= 1'b0;
            r_sOut <= '0;
            r_dOut <= '0;
        end else if (s_in[N]) begin
            if (!r_have) begin
                r_have <= 1'b1;
                r_dOut <= s_in;
                r_sOut <= '0;
            end else begin
                r_sOut <= s_in;
            end
        end else begin
            r_sOut <= '0;
        end
    end

    assign s_out = r_sOut;
    assign d_out = r_dOut;

endmodule
`default_nettype wire

// File: rtl/primitive_ap02_llii.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | primitive_ap02_llii                                                |
// | Pops two valid elements (d_out1, d_out0), passes the rest on s_out.|
// | PRIMITIVE_AP02_CHAINED_EN: build from two primitive_ap01_lli.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module primitive_ap02_llii
    import primitives_pkg::*;
#(
    parameter int N = c_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [N:0] s_in,
    output logic [N:0] s_out,
    output logic [N:0] d_out1,
    output logic [N:0] d_out0
);

`ifdef PRIMITIVE_AP02_CHAINED_EN

    logic [N:0] w_sA;

    primitive_ap01_lli #(.N(N)) u_stageA (
        .clk   (clk),
        .rst   (rst),
        .s_in  (s_in),
        .s_out (w_sA),
        .d_out (d_out1)
    );

    primitive_ap01_lli #(.N(N)) u_stageB (
        .clk   (clk),
        .rst   (rst),
        .s_in  (w_sA),
        .s_out (s_out),
        .d_out (d_out0)
    );

`else

    popCnt_e    r_cnt;
    popCnt_e    w_cntNext;
    logic [N:0] r_sOut;
    logic [N:0] r_dOut1;
    logic [N:0] r_dOut0;
    logic [N:0] w_sOutNext;
    logic [N:0] w_dOut1Next;
    logic [N:0] w_dOut0Next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= EMPTY;
            r_sOut  <= '0;
            r_dOut1 <= '0;
            r_dOut0 <= '0;
        end else begin
            r_cnt   <= w_cntNext;
            r_sOut  <= w_sOutNext;
            r_dOut1 <= w_dOut1Next;
            r_dOut0 <= w_dOut0Next;
        end
    end

    // Bubbles leave the counter and captured words alone and emit zero.
    always_comb begin
        w_cntNext   = r_cnt;
        w_sOutNext  = '0;
        w_dOut1Next = r_dOut1;
        w_dOut0Next = r_dOut0;
        if (s_in[N]) begin
            case (r_cnt)
                EMPTY: begin
                    w_dOut1Next = s_in;
                    w_cntNext   = ONE;
                end
                ONE: begin
                    w_dOut0Next = s_in;
                    w_cntNext   = BOTH;
                end
                default: begin
                    w_sOutNext  = s_in;
                end
            endcase
        end
    end

    assign s_out  = r_sOut;
    assign d_out1 = r_dOut1;
    assign d_out0 = r_dOut0;

`endif

endmodule
`default_nettype wire

// File: tb/tb_primitive_ap02_llii.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_primitive_ap02_llii                                             |
// | Bench for primitive_ap02_llii against an element-count model.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_primitive_ap02_llii;
    import primitives_pkg::*;

    localparam int c_TB_N = 8;

    logic              clk;
    logic              rst;
    logic [c_TB_N:0]   s_in;
    logic [c_TB_N:0]   s_out;
    logic [c_TB_N:0]   d_out1;
    logic [c_TB_N:0]   d_out0;

    int n_cmp;
    int n_fail;

    // Model state: valid elements seen since reset and the un-delayed outputs.
    int              m_vcount;
    logic [c_TB_N:0] m_s, m_d1, m_d0;
    logic [c_TB_N:0] e_s, e_d1, e_d0;

    primitive_ap02_llii #(.N(c_TB_N)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_in   (s_in),
        .s_out  (s_out),
        .d_out1 (d_out1),
        .d_out0 (d_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [c_TB_N:0] x);
        logic [c_TB_N:0] prev_s;
        logic [c_TB_N:0] prev_d0;
        @(negedge clk);
        rst  = r;
        s_in = x;
        @(posedge clk);
        #1;
        prev_s  = m_s;
        prev_d0 = m_d0;
        if (r) begin
            m_vcount = 0;
            m_s = '0; m_d1 = '0; m_d0 = '0;
        end else if (x[c_TB_N]) begin
            m_vcount++;
            if (m_vcount == 1)      m_d1 = x;
            else if (m_vcount == 2) m_d0 = x;
            m_s = (m_vcount > 2) ? x : '0;
        end else begin
            m_s = '0;
        end
        e_d1 = m_d1;
`ifdef PRIMITIVE_AP02_CHAINED_EN
        e_s  = r ? '0 : prev_s;
        e_d0 = r ? '0 : prev_d0;
`else
        e_s  = m_s;
        e_d0 = m_d0;
`endif
    endtask

    task automatic test_reset();
        step(1'b1, read(8'd5));
        step(1'b1, '0);
        n_cmp++;
        if (s_out !== 9'h000) begin n_fail++; $display("FAIL reset_s_out got=%h want=000", s_out); end
        n_cmp++;
        if (d_out1 !== 9'h000) begin n_fail++; $display("FAIL reset_d_out1 got=%h want=000", d_out1); end
        n_cmp++;
        if (d_out0 !== 9'h000) begin n_fail++; $display("FAIL reset_d_out0 got=%h want=000", d_out0); end
    endtask

    task automatic test_sequence();
        logic [c_TB_N:0] seq [6];
        logic [c_TB_N:0] sout_seen [$];
        seq[0] = read(8'd1); seq[1] = read(8'd2); seq[2] = read(8'd3);
        seq[3] = read(8'd4); seq[4] = '0;         seq[5] = '0;
        step(1'b1, '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, seq[i]);
            if (s_out[c_TB_N]) sout_seen.push_back(s_out);
            n_cmp++;
            if (s_out !== e_s) begin n_fail++; $display("FAIL seq_s_out[%0d] got=%h want=%h", i, s_out, e_s); end
            n_cmp++;
            if (d_out1 !== e_d1) begin n_fail++; $display("FAIL seq_d_out1[%0d] got=%h want=%h", i, d_out1, e_d1); end
            n_cmp++;
            if (d_out0 !== e_d0) begin n_fail++; $display("FAIL seq_d_out0[%0d] got=%h want=%h", i, d_out0, e_d0); end
        end
        n_cmp++;
        if (d_out1 !== 9'h101 || d_out0 !== 9'h102) begin
            n_fail++; $display("FAIL seq_pops got=%h/%h want=101/102", d_out1, d_out0);
        end
        n_cmp++;
        if (sout_seen.size() != 2 || sout_seen[0] !== 9'h103 || sout_seen[1] !== 9'h104) begin
            n_fail++; $display("FAIL seq_remainder got_count=%0d want=2 (103,104)", sout_seen.size());
        end
    endtask

    task automatic test_bubbles();
        step(1'b1, '0);
        step(1'b0, read(8'd1));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, {1'b0, 8'(i + 2)});
            n_cmp++;
            if (s_out !== 9'h000) begin n_fail++; $display("FAIL bub_s_out[%0d] got=%h want=000", i, s_out); end
            n_cmp++;
            if (d_out0 !== e_d0) begin n_fail++; $display("FAIL bub_d_out0[%0d] got=%h want=%h", i, d_out0, e_d0); end
        end
        step(1'b0, read(8'd6));
        step(1'b0, '0);
        n_cmp++;
        if (d_out0 !== 9'h106) begin n_fail++; $display("FAIL bub_final_d_out0 got=%h want=106", d_out0); end
        n_cmp++;
        if (s_out !== 9'h000) begin n_fail++; $display("FAIL bub_final_s_out got=%h want=000", s_out); end
    endtask

    task automatic test_all_ones();
        logic seen;
        seen = 1'b0;
        step(1'b1, '0);
        step(1'b0, read(8'd10));
        step(1'b0, read(8'd11));
        step(1'b0, read(8'hFF));
        if (s_out === 9'h1FF) seen = 1'b1;
        step(1'b0, '0);
        if (s_out === 9'h1FF) seen = 1'b1;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL all_ones_pass got=%h want=1ff", s_out); end
        n_cmp++;
        if (d_out1 !== 9'h10A || d_out0 !== 9'h10B) begin
            n_fail++; $display("FAIL all_ones_pops got=%h/%h want=10a/10b", d_out1, d_out0);
        end
    endtask

    task automatic test_midreset();
        step(1'b0, read(8'd7));
        step(1'b0, read(8'd8));
        step(1'b0, '0);
        step(1'b1, '0);
        n_cmp++;
        if ({s_out, d_out1, d_out0} !== 27'd0) begin
            n_fail++; $display("FAIL midreset_zero got=%h/%h/%h want=0/0/0", s_out, d_out1, d_out0);
        end
        step(1'b0, read(8'd9));
        n_cmp++;
        if (d_out1 !== 9'h109) begin n_fail++; $display("FAIL midreset_d_out1 got=%h want=109", d_out1); end
    endtask

    task automatic test_reset_with_valid();
        step(1'b0, read(8'd3));
        step(1'b1, read(8'd44));
        n_cmp++;
        if ({s_out, d_out1, d_out0} !== 27'd0) begin
            n_fail++; $display("FAIL rstvalid_zero got=%h/%h/%h want=0/0/0", s_out, d_out1, d_out0);
        end
        step(1'b0, read(8'd55));
        n_cmp++;
        if (d_out1 !== 9'h137) begin n_fail++; $display("FAIL rstvalid_first got=%h want=137", d_out1); end
    endtask

    task automatic test_random();
        logic            r;
        logic [c_TB_N:0] x;
        step(1'b1, '0);
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 39) == 0);
            x = {($urandom_range(0, 9) < 7), 8'($urandom)};
            step(r, x);
            n_cmp++;
            if (s_out !== e_s) begin n_fail++; $display("FAIL rnd_s_out[%0d] got=%h want=%h", i, s_out, e_s); end
            n_cmp++;
            if (d_out1 !== e_d1) begin n_fail++; $display("FAIL rnd_d_out1[%0d] got=%h want=%h", i, d_out1, e_d1); end
            n_cmp++;
            if (d_out0 !== e_d0) begin n_fail++; $display("FAIL rnd_d_out0[%0d] got=%h want=%h", i, d_out0, e_d0); end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        m_vcount = 0;
        m_s = '0; m_d1 = '0; m_d0 = '0;
        e_s = '0; e_d1 = '0; e_d0 = '0;
        rst  = 1'b1;
        s_in = '0;
        test_reset();
        test_sequence();
        test_bubbles();
        test_all_ones();
        test_midreset();
        test_reset_with_valid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
